// File: rtl/wt_dcache_rd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wt_dcache_rd_ctrl_pkg
// Shared definitions for the write-through L1 dcache read controller:
// geometry localparams, the miss transaction ID, the cacheable window,
// the controller state enum and the is_cacheable() address check.
// -----------------------------------------------------------------------------
package wt_dcache_rd_ctrl_pkg;

  localparam int SET_ASSOC = 8;
  localparam int TAG_W     = 44;
  localparam int CL_IDX_W  = 8;
  localparam int OFF_W     = 4;
  localparam int ID_W      = 2;

  localparam int IDX_W   = CL_IDX_W + OFF_W;  // untranslated part of the address
  localparam int PADDR_W = TAG_W + IDX_W;

  localparam logic [ID_W-1:0]    RD_TX_ID    = ID_W'(1);
  localparam logic [PADDR_W-1:0] CACHED_BASE = PADDR_W'(64'h8000_0000);
  localparam logic [PADDR_W-1:0] CACHED_SIZE = PADDR_W'(64'h4000_0000);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MISS_REQ,
    MISS_WAIT,
    KILL_MISS,
    KILL_MISS_ACK,
    REPLAY_REQ,
    REPLAY_READ
  } rd_state_e;

  // True when the physical address falls in [CACHED_BASE, CACHED_BASE+CACHED_SIZE).
  function automatic logic is_cacheable(input logic [PADDR_W-1:0] paddr);
    return (paddr >= CACHED_BASE) && (paddr < (CACHED_BASE + CACHED_SIZE));
  endfunction

endpackage

// File: rtl/wt_dcache_rd_ctrl.sv
// -----------------------------------------------------------------------------
// wt_dcache_rd_ctrl
// Read controller for one load/PTW port of the write-through L1 dcache.
// Arbitrates core reads into the cache memory read port, resolves hit/miss,
// forwards misses and non-cacheable reads to the miss unit, and returns
// exactly one rvalid_o per gnt_o (killed requests included).
//
// Optional feature: define WT_DCACHE_RD_CTRL_PIPELINE_EN to let a READ hit
// accept the next request in the same cycle (1 load/cycle). Without it a hit
// returns to IDLE, giving at most one grant every two cycles.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cache_en_i            0 makes every access non-cacheable
//   busy_o                controller not in IDLE
//   req_i/kill_i/idx_i/tag_i/tag_valid_i/size_i   core request side
//   gnt_o/rvalid_o/rdata_o                        core response side
//   miss_*                miss unit request / handshake / return
//   wr_cl_vld_i           refill or invalidate collides with our readout
//   rd_*                  cache memory read port
// -----------------------------------------------------------------------------
module wt_dcache_rd_ctrl
  import wt_dcache_rd_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cache_en_i,
  output logic                 busy_o,
  // core port
  input  logic                 req_i,
  input  logic                 kill_i,
  input  logic [IDX_W-1:0]     idx_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic                 tag_valid_i,
  input  logic [1:0]           size_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [63:0]          rdata_o,
  // miss unit
  output logic                 miss_req_o,
  input  logic                 miss_ack_i,
  input  logic                 miss_replay_i,
  input  logic                 miss_rtrn_vld_i,
  output logic [PADDR_W-1:0]   miss_paddr_o,
  output logic [2:0]           miss_size_o,
  output logic                 miss_nc_o,
  output logic                 miss_we_o,
  output logic [63:0]          miss_wdata_o,
  output logic [SET_ASSOC-1:0] miss_vld_bits_o,
  output logic [ID_W-1:0]      miss_id_o,
  input  logic                 wr_cl_vld_i,
  // cache memory
  output logic                 rd_req_o,
  input  logic                 rd_ack_i,
  output logic                 rd_tag_only_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic [CL_IDX_W-1:0]  rd_idx_o,
  output logic [OFF_W-1:0]     rd_off_o,
  input  logic [63:0]          rd_data_i,
  input  logic [SET_ASSOC-1:0] rd_vld_bits_i,
  input  logic [SET_ASSOC-1:0] rd_hit_oh_i
);

  rd_state_e            state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [1:0]           size_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 tag_vld_q;   // tag for the current READ already captured
  logic [SET_ASSOC-1:0] vld_bits_q;

  logic load_req;   // accept a new request: capture idx/size
  logic latch_tag;
  logic latch_vld;

  logic [TAG_W-1:0] tag_cur;
  logic             tag_ok;
  logic             nc;
  logic             hit;

  // In READ the tag may arrive in the very cycle we resolve hit/miss, so use
  // it directly; everywhere else the captured tag is authoritative.
  assign tag_cur = (state_q == READ && tag_valid_i) ? tag_i : tag_q;
  assign tag_ok  = (state_q == REPLAY_READ) | tag_valid_i | tag_vld_q;
  assign nc      = !cache_en_i | !is_cacheable({tag_cur, idx_q});
  assign hit     = (|rd_hit_oh_i) & !nc;

  // Memory bypasses the refill word onto rd_data_i during the return cycle,
  // so one path serves both hits and miss returns.
  assign rdata_o = rd_data_i;

  // A new read is addressed straight from the core; replays reuse the
  // captured index.
  always_comb begin
    if (state_q == IDLE || state_q == READ) begin
      rd_idx_o = idx_i[IDX_W-1:OFF_W];
      rd_off_o = idx_i[OFF_W-1:0];
    end else begin
      rd_idx_o = idx_q[IDX_W-1:OFF_W];
      rd_off_o = idx_q[OFF_W-1:0];
    end
  end

  assign rd_tag_o        = tag_q;
  assign rd_tag_only_o   = 1'b0;
  assign busy_o          = (state_q != IDLE);
  assign miss_paddr_o    = {tag_q, idx_q};
  assign miss_size_o     = {1'b0, size_q};
  assign miss_nc_o       = nc;
  assign miss_we_o       = 1'b0;
  assign miss_wdata_o    = '0;
  assign miss_id_o       = RD_TX_ID;
  assign miss_vld_bits_o = vld_bits_q;

  // Handshake outputs are combinational: gnt_o answers rd_ack_i and rvalid_o
  // must line up with rd_data_i in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d    = state_q;
    gnt_o      = 1'b0;
    rvalid_o   = 1'b0;
    rd_req_o   = 1'b0;
    miss_req_o = 1'b0;
    load_req   = 1'b0;
    latch_tag  = 1'b0;
    latch_vld  = 1'b0;

    case (state_q)
      IDLE: begin
        rd_req_o = req_i;
        if (req_i && rd_ack_i) begin
          gnt_o    = 1'b1;
          load_req = 1'b1;
          state_d  = READ;
        end
      end

      READ, REPLAY_READ: begin
        latch_tag = (state_q == READ) && tag_valid_i;
        // kill wins over every hit/miss/collision outcome
        if (kill_i) begin
          rvalid_o = 1'b1;
          state_d  = IDLE;
        end else if (tag_ok) begin
          if (wr_cl_vld_i) begin
            state_d = REPLAY_REQ;
          end else if (hit) begin
            rvalid_o = 1'b1;
            state_d  = IDLE;
`ifdef WT_DCACHE_RD_CTRL_PIPELINE_EN
            // Overlap the next lookup with this hit response.
            if (state_q == READ) begin
              rd_req_o = req_i;
              if (req_i && rd_ack_i) begin
                gnt_o    = 1'b1;
                load_req = 1'b1;
                state_d  = READ;
              end
            end
`endif
          end else begin
            latch_vld = 1'b1;
            state_d   = MISS_REQ;
          end
        end
      end

      MISS_REQ: begin
        miss_req_o = 1'b1;
        if (kill_i) begin
          // Respond now; a request already acked still owes us a return.
          rvalid_o = 1'b1;
          state_d  = miss_ack_i ? KILL_MISS : KILL_MISS_ACK;
        end else if (miss_replay_i) begin
          state_d = REPLAY_REQ;
        end else if (miss_ack_i) begin
          state_d = MISS_WAIT;
        end
      end

      MISS_WAIT: begin
        if (miss_rtrn_vld_i) begin
          rvalid_o = 1'b1;
          state_d  = IDLE;
        end else if (kill_i) begin
          rvalid_o = 1'b1;
          state_d  = KILL_MISS;
        end
      end

      KILL_MISS_ACK: begin
        miss_req_o = 1'b1;
        if (miss_ack_i) begin
          state_d = KILL_MISS;
        end else if (miss_replay_i) begin
          state_d = IDLE;
        end
      end

      KILL_MISS: begin
        // Swallow the return of a killed miss; rvalid was already given.
        if (miss_rtrn_vld_i) begin
          state_d = IDLE;
        end
      end

      REPLAY_REQ: begin
        rd_req_o = 1'b1;
        if (kill_i) begin
          rvalid_o = 1'b1;
          state_d  = IDLE;
        end else if (rd_ack_i) begin
          state_d = REPLAY_READ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the reset is
  // synchronous and clears every register since there is no storage array.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      size_q     <= '0;
      tag_q      <= '0;
      tag_vld_q  <= 1'b0;
      vld_bits_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_tag) begin
        tag_q     <= tag_i;
        tag_vld_q <= 1'b1;
      end
      // A new grant starts a fresh request; it must win over latch_tag,
      // which belongs to the request being retired.
      if (load_req) begin
        idx_q     <= idx_i;
        size_q    <= size_i;
        tag_vld_q <= 1'b0;
      end
      if (latch_vld) begin
        vld_bits_q <= rd_vld_bits_i;
      end
    end
  end

endmodule

// File: tb/tb_wt_dcache_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wt_dcache_rd_ctrl
// Directed bench for wt_dcache_rd_ctrl. Inputs change 2 time units after the
// rising edge and outputs are compared 1 unit later. The control outputs are
// compared as one vector: ctrl = {gnt, rvalid, rd_req, miss_req, busy}.
// Honours WT_DCACHE_RD_CTRL_PIPELINE_EN for the back-to-back expectations.
// -----------------------------------------------------------------------------
module tb_wt_dcache_rd_ctrl;
  import wt_dcache_rd_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 cache_en_i;
  logic                 busy_o;
  logic                 req_i, kill_i, tag_valid_i;
  logic [IDX_W-1:0]     idx_i;
  logic [TAG_W-1:0]     tag_i;
  logic [1:0]           size_i;
  logic                 gnt_o, rvalid_o;
  logic [63:0]          rdata_o;
  logic                 miss_req_o, miss_ack_i, miss_replay_i, miss_rtrn_vld_i;
  logic [PADDR_W-1:0]   miss_paddr_o;
  logic [2:0]           miss_size_o;
  logic                 miss_nc_o, miss_we_o;
  logic [63:0]          miss_wdata_o;
  logic [SET_ASSOC-1:0] miss_vld_bits_o;
  logic [ID_W-1:0]      miss_id_o;
  logic                 wr_cl_vld_i;
  logic                 rd_req_o, rd_ack_i, rd_tag_only_o;
  logic [TAG_W-1:0]     rd_tag_o;
  logic [CL_IDX_W-1:0]  rd_idx_o;
  logic [OFF_W-1:0]     rd_off_o;
  logic [63:0]          rd_data_i;
  logic [SET_ASSOC-1:0] rd_vld_bits_i, rd_hit_oh_i;

  logic [4:0] ctrl;
  assign ctrl = {gnt_o, rvalid_o, rd_req_o, miss_req_o, busy_o};

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wt_dcache_rd_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .cache_en_i(cache_en_i), .busy_o(busy_o),
    .req_i(req_i), .kill_i(kill_i), .idx_i(idx_i), .tag_i(tag_i),
    .tag_valid_i(tag_valid_i), .size_i(size_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .miss_req_o(miss_req_o), .miss_ack_i(miss_ack_i), .miss_replay_i(miss_replay_i),
    .miss_rtrn_vld_i(miss_rtrn_vld_i), .miss_paddr_o(miss_paddr_o),
    .miss_size_o(miss_size_o), .miss_nc_o(miss_nc_o), .miss_we_o(miss_we_o),
    .miss_wdata_o(miss_wdata_o), .miss_vld_bits_o(miss_vld_bits_o),
    .miss_id_o(miss_id_o), .wr_cl_vld_i(wr_cl_vld_i),
    .rd_req_o(rd_req_o), .rd_ack_i(rd_ack_i), .rd_tag_only_o(rd_tag_only_o),
    .rd_tag_o(rd_tag_o), .rd_idx_o(rd_idx_o), .rd_off_o(rd_off_o),
    .rd_data_i(rd_data_i), .rd_vld_bits_i(rd_vld_bits_i), .rd_hit_oh_i(rd_hit_oh_i)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    cache_en_i = 1'b1;   req_i = 1'b0;        kill_i = 1'b0;
    idx_i = '0;          tag_i = '0;          tag_valid_i = 1'b0;
    size_i = '0;         miss_ack_i = 1'b0;   miss_replay_i = 1'b0;
    miss_rtrn_vld_i = 1'b0; wr_cl_vld_i = 1'b0; rd_ack_i = 1'b0;
    rd_data_i = '0;      rd_vld_bits_i = '0;  rd_hit_oh_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    #1;
    vectors++; if (ctrl !== 5'b00000) begin miscompares++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 5'b00000); end
    vectors++; if (miss_paddr_o !== '0) begin miscompares++; $display("FAIL reset_paddr got=%h exp=0", miss_paddr_o); end
    vectors++; if (miss_vld_bits_o !== '0 || miss_we_o !== 1'b0 || rd_tag_only_o !== 1'b0) begin miscompares++; $display("FAIL reset_misc vld=%h we=%b tagonly=%b exp=0", miss_vld_bits_o, miss_we_o, rd_tag_only_o); end
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_hit();
    cyc(); idle_inputs(); req_i = 1'b1; idx_i = 12'h010; size_i = 2'd3; rd_ack_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b10100) begin miscompares++; $display("FAIL hit_gnt ctrl got=%b exp=%b", ctrl, 5'b10100); end
    vectors++; if ({rd_idx_o, rd_off_o} !== 12'h010) begin miscompares++; $display("FAIL hit_rd_addr got=%h exp=010", {rd_idx_o, rd_off_o}); end
    cyc(); idle_inputs(); tag_i = 44'h80000; tag_valid_i = 1'b1; rd_hit_oh_i = 8'h01; rd_data_i = 64'hDEAD; #1;
    vectors++; if (ctrl !== 5'b01001) begin miscompares++; $display("FAIL hit_rvalid ctrl got=%b exp=%b", ctrl, 5'b01001); end
    vectors++; if (rdata_o !== 64'hDEAD) begin miscompares++; $display("FAIL hit_rdata got=%h exp=dead", rdata_o); end
    cyc(); idle_inputs(); #1;
    vectors++; if (ctrl !== 5'b00000) begin miscompares++; $display("FAIL hit_idle ctrl got=%b exp=%b", ctrl, 5'b00000); end
    vectors++; if (rd_tag_o !== 44'h80000) begin miscompares++; $display("FAIL hit_tag_q got=%h exp=80000", rd_tag_o); end
  endtask

  task automatic test_miss();
    cyc(); idle_inputs(); req_i = 1'b1; idx_i = 12'h234; size_i = 2'd2; rd_ack_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b10100) begin miscompares++; $display("FAIL miss_gnt ctrl got=%b exp=%b", ctrl, 5'b10100); end
    // tag not yet valid: must wait even though a way reports a hit
    cyc(); idle_inputs(); rd_hit_oh_i = 8'h01; #1;
    vectors++; if (ctrl !== 5'b00001) begin miscompares++; $display("FAIL miss_tag_wait ctrl got=%b exp=%b", ctrl, 5'b00001); end
    cyc(); idle_inputs(); tag_i = 44'h80001; tag_valid_i = 1'b1; rd_vld_bits_i = 8'h0F; #1;
    vectors++; if (ctrl !== 5'b00001) begin miscompares++; $display("FAIL miss_detect ctrl got=%b exp=%b", ctrl, 5'b00001); end
    cyc(); idle_inputs(); miss_ack_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b00011) begin miscompares++; $display("FAIL miss_req ctrl got=%b exp=%b", ctrl, 5'b00011); end
    vectors++; if (miss_paddr_o !== {44'h80001, 12'h234}) begin miscompares++; $display("FAIL miss_paddr got=%h exp=%h", miss_paddr_o, {44'h80001, 12'h234}); end
    vectors++; if (miss_vld_bits_o !== 8'h0F) begin miscompares++; $display("FAIL miss_vld_bits got=%h exp=0f", miss_vld_bits_o); end
    vectors++; if ({miss_size_o, miss_nc_o, miss_id_o} !== {3'b010, 1'b0, 2'd1}) begin miscompares++; $display("FAIL miss_fields size/nc/id got=%b exp=%b", {miss_size_o, miss_nc_o, miss_id_o}, {3'b010, 1'b0, 2'd1}); end
    cyc(); idle_inputs(); #1;
    vectors++; if (ctrl !== 5'b00001) begin miscompares++; $display("FAIL miss_wait ctrl got=%b exp=%b", ctrl, 5'b00001); end
    cyc(); idle_inputs(); miss_rtrn_vld_i = 1'b1; rd_data_i = 64'hCAFE; #1;
    vectors++; if (ctrl !== 5'b01001 || rdata_o !== 64'hCAFE) begin miscompares++; $display("FAIL miss_rtrn ctrl got=%b exp=%b rdata got=%h exp=cafe", ctrl, 5'b01001, rdata_o); end
    cyc(); idle_inputs(); #1;
    vectors++; if (ctrl !== 5'b00000) begin miscompares++; $display("FAIL miss_idle ctrl got=%b exp=%b", ctrl, 5'b00000); end
  endtask

  // One transaction where every way reports a hit; expect_nc selects whether
  // the controller must turn it into a non-cacheable miss instead.
  task automatic nc_case(input string name, input logic [TAG_W-1:0] tag,
                         input logic [IDX_W-1:0] idx, input logic en, input logic expect_nc);
    cyc(); idle_inputs(); req_i = 1'b1; idx_i = idx; rd_ack_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b10100) begin miscompares++; $display("FAIL %s_gnt ctrl got=%b exp=%b", name, ctrl, 5'b10100); end
    cyc(); idle_inputs(); cache_en_i = en; tag_i = tag; tag_valid_i = 1'b1; rd_hit_oh_i = 8'h01; #1;
    if (expect_nc) begin
      vectors++; if (ctrl !== 5'b00001) begin miscompares++; $display("FAIL %s_no_hit ctrl got=%b exp=%b", name, ctrl, 5'b00001); end
      cyc(); idle_inputs(); cache_en_i = en; miss_ack_i = 1'b1; #1;
      vectors++; if (ctrl !== 5'b00011 || miss_nc_o !== 1'b1) begin miscompares++; $display("FAIL %s_nc_req ctrl got=%b exp=%b nc got=%b exp=1", name, ctrl, 5'b00011, miss_nc_o); end
      cyc(); idle_inputs(); miss_rtrn_vld_i = 1'b1; #1;
      vectors++; if (ctrl !== 5'b01001) begin miscompares++; $display("FAIL %s_rtrn ctrl got=%b exp=%b", name, ctrl, 5'b01001); end
    end else begin
      vectors++; if (ctrl !== 5'b01001) begin miscompares++; $display("FAIL %s_hit ctrl got=%b exp=%b", name, ctrl, 5'b01001); end
    end
    cyc(); idle_inputs(); #1;
    vectors++; if (ctrl !== 5'b00000) begin miscompares++; $display("FAIL %s_idle ctrl got=%b exp=%b", name, ctrl, 5'b00000); end
  endtask

  task automatic test_nc();
    nc_case("nc_below",  44'h7FFFF, 12'hFFF, 1'b1, 1'b1);  // 0x7FFF_FFFF
    nc_case("nc_off",    44'h80000, 12'h000, 1'b0, 1'b1);  // cache disabled
    nc_case("nc_top",    44'hC0000, 12'h000, 1'b1, 1'b1);  // first byte past the window
    nc_case("c_last",    44'hBFFFF, 12'hFFF, 1'b1, 1'b0);  // last cacheable byte
  endtask

  task automatic test_kill();
    // kill while waiting for the return
    cyc(); idle_inputs(); req_i = 1'b1; idx_i = 12'h100; rd_ack_i = 1'b1; #1;
    cyc(); idle_inputs(); tag_i = 44'h80003; tag_valid_i = 1'b1; #1;
    cyc(); idle_inputs(); miss_ack_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b00011) begin miscompares++; $display("FAIL kw_req ctrl got=%b exp=%b", ctrl, 5'b00011); end
    cyc(); idle_inputs(); kill_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b01001) begin miscompares++; $display("FAIL kw_kill ctrl got=%b exp=%b", ctrl, 5'b01001); end
    cyc(); idle_inputs(); #1;
    vectors++; if (ctrl !== 5'b00001) begin miscompares++; $display("FAIL kw_hold ctrl got=%b exp=%b", ctrl, 5'b00001); end
    cyc(); idle_inputs(); miss_rtrn_vld_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b00001) begin miscompares++; $display("FAIL kw_rtrn ctrl got=%b exp=%b", ctrl, 5'b00001); end
    cyc(); idle_inputs(); #1;
    vectors++; if (ctrl !== 5'b00000) begin miscompares++; $display("FAIL kw_idle ctrl got=%b exp=%b", ctrl, 5'b00000); end
    // kill in MISS_REQ before the ack
    cyc(); idle_inputs(); req_i = 1'b1; idx_i = 12'h100; rd_ack_i = 1'b1; #1;
    cyc(); idle_inputs(); tag_i = 44'h80003; tag_valid_i = 1'b1; #1;
    cyc(); idle_inputs(); kill_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b01011) begin miscompares++; $display("FAIL kr_kill ctrl got=%b exp=%b", ctrl, 5'b01011); end
    cyc(); idle_inputs(); #1;
    vectors++; if (ctrl !== 5'b00011) begin miscompares++; $display("FAIL kr_ack_wait ctrl got=%b exp=%b", ctrl, 5'b00011); end
    cyc(); idle_inputs(); miss_ack_i = 1'b1; #1;
    cyc(); idle_inputs(); miss_rtrn_vld_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b00001) begin miscompares++; $display("FAIL kr_rtrn ctrl got=%b exp=%b", ctrl, 5'b00001); end
    cyc(); idle_inputs(); #1;
    vectors++; if (ctrl !== 5'b00000) begin miscompares++; $display("FAIL kr_idle ctrl got=%b exp=%b", ctrl, 5'b00000); end
    // kill beats a miss decision in READ
    cyc(); idle_inputs(); req_i = 1'b1; idx_i = 12'h100; rd_ack_i = 1'b1; #1;
    cyc(); idle_inputs(); tag_i = 44'h80003; tag_valid_i = 1'b1; kill_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b01001) begin miscompares++; $display("FAIL kd_kill ctrl got=%b exp=%b", ctrl, 5'b01001); end
    cyc(); idle_inputs(); #1;
    vectors++; if (ctrl !== 5'b00000) begin miscompares++; $display("FAIL kd_idle ctrl got=%b exp=%b", ctrl, 5'b00000); end
  endtask

  task automatic test_replay();
    cyc(); idle_inputs(); req_i = 1'b1; idx_i = 12'h3C8; rd_ack_i = 1'b1; #1;
    cyc(); idle_inputs(); tag_i = 44'h80002; tag_valid_i = 1'b1; wr_cl_vld_i = 1'b1; rd_hit_oh_i = 8'h01; #1;
    vectors++; if (ctrl !== 5'b00001) begin miscompares++; $display("FAIL rp_collide ctrl got=%b exp=%b", ctrl, 5'b00001); end
    cyc(); idle_inputs(); idx_i = 12'h555; #1;
    vectors++; if (ctrl !== 5'b00101) begin miscompares++; $display("FAIL rp_req ctrl got=%b exp=%b", ctrl, 5'b00101); end
    vectors++; if ({rd_idx_o, rd_off_o} !== 12'h3C8 || rd_tag_o !== 44'h80002) begin miscompares++; $display("FAIL rp_addr idx got=%h exp=3c8 tag got=%h exp=80002", {rd_idx_o, rd_off_o}, rd_tag_o); end
    cyc(); idle_inputs(); rd_ack_i = 1'b1; #1;
    vectors++; if (ctrl !== 5'b00101) begin miscompares++; $display("FAIL rp_ack ctrl got=%b exp=%b", ctrl, 5'b00101); end
    // a pending core request must not be granted out of REPLAY_READ
    cyc(); idle_inputs(); req_i = 1'b1; rd_ack_i = 1'b1; idx_i = 12'h555; rd_hit_oh_i = 8'h01; rd_data_i = 64'hBEEF; #1;
    vectors++; if (ctrl !== 5'b01001 || rdata_o !== 64'hBEEF) begin miscompares++; $display("FAIL rp_hit ctrl got=%b exp=%b rdata got=%h exp=beef", ctrl, 5'b01001, rdata_o); end
    cyc(); idle_inputs(); #1;
    vectors++; if (ctrl !== 5'b00000) begin miscompares++; $display("FAIL rp_idle ctrl got=%b exp=%b", ctrl, 5'b00000); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_tab [9];
    int n;
    int grants = 0;
`ifdef WT_DCACHE_RD_CTRL_PIPELINE_EN
    n = 6;
    exp_tab[0] = 5'b10100; exp_tab[1] = 5'b11101; exp_tab[2] = 5'b11101;
    exp_tab[3] = 5'b11101; exp_tab[4] = 5'b01001; exp_tab[5] = 5'b00000;
    for (int i = 6; i < 9; i++) exp_tab[i] = 5'b00000;
`else
    n = 9;
    for (int i = 0; i < 8; i++) exp_tab[i] = i[0] ? 5'b01001 : 5'b10100;
    exp_tab[8] = 5'b00000;
`endif
    for (int c = 0; c < n; c++) begin
      cyc(); idle_inputs();
      req_i = (grants < 4); rd_ack_i = req_i; idx_i = IDX_W'(c * 16);
      tag_i = 44'h80000; tag_valid_i = 1'b1; rd_hit_oh_i = 8'h01;
      #1;
      vectors++; if (ctrl !== exp_tab[c]) begin miscompares++; $display("FAIL b2b_cycle%0d ctrl got=%b exp=%b", c, ctrl, exp_tab[c]); end
      if (gnt_o) grants++;
    end
    cyc(); idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_nc();
    test_kill();
    test_replay();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
